// File: rtl/regfile_wb_arbiter.sv
// Register file write-back arbiter: three requesters share one write port.
// Each source feeds a one-entry buffer; a round-robin pick drains one per cycle.
module regfile_wb_arbiter #(
   parameter int A = 4,
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [A-1:0]        alu_addr,
   input  logic [W-1:0]        alu_data,
   input  logic                acc_valid,
   output logic                acc_ready,
   input  logic [A-1:0]        acc_addr,
   input  logic [W-1:0]        acc_data,
   input  logic                mem_valid,
   output logic                mem_ready,
   input  logic [A-1:0]        mem_addr,
   input  logic [W-1:0]        mem_data,
   output logic                Write_En,
   output logic                from_ALU,
   output logic                from_Acc,
   output logic                from_Mem,
   output logic [A-1:0]        address,
   output logic [W-1:0]        ALU_Input,
   output logic [W-1:0]        Acc_Input,
   output logic [W-1:0]        Mem_Input,
   output logic [(1<<A)-1:0]   pending
);

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_ACC = 2'd1,
      SRC_MEM = 2'd2
   } src_e;

   logic          r_alu_full;
   logic [A-1:0]  r_alu_addr;
   logic [W-1:0]  r_alu_data;
   logic          r_acc_full;
   logic [A-1:0]  r_acc_addr;
   logic [W-1:0]  r_acc_data;
   logic          r_mem_full;
   logic [A-1:0]  r_mem_addr;
   logic [W-1:0]  r_mem_data;
   src_e          r_ptr;

   logic          w_gnt_alu;
   logic          w_gnt_acc;
   logic          w_gnt_mem;
   logic          w_cap_alu;
   logic          w_cap_acc;
   logic          w_cap_mem;
   logic [(1<<A)-1:0] w_pending;

   // Rotating-priority pick among full buffers; nothing is granted in reset
   // so buffered writes are discarded without a strobe.
   always_comb begin
      w_gnt_alu = 1'b0;
      w_gnt_acc = 1'b0;
      w_gnt_mem = 1'b0;
      if (!Reset) begin
         case (r_ptr)
            SRC_ACC: begin
               if (r_acc_full)      w_gnt_acc = 1'b1;
               else if (r_mem_full) w_gnt_mem = 1'b1;
               else if (r_alu_full) w_gnt_alu = 1'b1;
            end
            SRC_MEM: begin
               if (r_mem_full)      w_gnt_mem = 1'b1;
               else if (r_alu_full) w_gnt_alu = 1'b1;
               else if (r_acc_full) w_gnt_acc = 1'b1;
            end
            default: begin
               if (r_alu_full)      w_gnt_alu = 1'b1;
               else if (r_acc_full) w_gnt_acc = 1'b1;
               else if (r_mem_full) w_gnt_mem = 1'b1;
            end
         endcase
      end
   end

   // Ready depends only on buffer state and grant, never on valid.
   assign alu_ready = !r_alu_full || w_gnt_alu;
   assign acc_ready = !r_acc_full || w_gnt_acc;
   assign mem_ready = !r_mem_full || w_gnt_mem;

   assign w_cap_alu = alu_valid && alu_ready;
   assign w_cap_acc = acc_valid && acc_ready;
   assign w_cap_mem = mem_valid && mem_ready;

   // ALU holding buffer: a refill in the grant cycle keeps it full.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_alu_full <= 1'b0;
         r_alu_addr <= '0;
         r_alu_data <= '0;
      end else if (w_cap_alu) begin
         r_alu_full <= 1'b1;
         r_alu_addr <= alu_addr;
         r_alu_data <= alu_data;
      end else if (w_gnt_alu) begin
         r_alu_full <= 1'b0;
      end
   end

   // Accumulator holding buffer.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_acc_full <= 1'b0;
         r_acc_addr <= '0;
         r_acc_data <= '0;
      end else if (w_cap_acc) begin
         r_acc_full <= 1'b1;
         r_acc_addr <= acc_addr;
         r_acc_data <= acc_data;
      end else if (w_gnt_acc) begin
         r_acc_full <= 1'b0;
      end
   end

   // Memory holding buffer.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_mem_full <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else if (w_cap_mem) begin
         r_mem_full <= 1'b1;
         r_mem_addr <= mem_addr;
         r_mem_data <= mem_data;
      end else if (w_gnt_mem) begin
         r_mem_full <= 1'b0;
      end
   end

   // Pointer moves past the granted source; it holds when idle.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_ptr <= SRC_ALU;
      end else if (w_gnt_alu) begin
         r_ptr <= SRC_ACC;
      end else if (w_gnt_acc) begin
         r_ptr <= SRC_MEM;
      end else if (w_gnt_mem) begin
         r_ptr <= SRC_ALU;
      end
   end

   // Register-file write controls follow the grant in the same cycle.
   assign Write_En  = w_gnt_alu || w_gnt_acc || w_gnt_mem;
   assign from_ALU  = w_gnt_alu;
   assign from_Acc  = w_gnt_acc;
   assign from_Mem  = w_gnt_mem;
   assign address   = ({A{w_gnt_alu}} & r_alu_addr)
                    | ({A{w_gnt_acc}} & r_acc_addr)
                    | ({A{w_gnt_mem}} & r_mem_addr);
   assign ALU_Input = w_gnt_alu ? r_alu_data : '0;
   assign Acc_Input = w_gnt_acc ? r_acc_data : '0;
   assign Mem_Input = w_gnt_mem ? r_mem_data : '0;

   // Hazard mask: one bit per destination held in any buffer.
   always_comb begin
      w_pending = '0;
      if (r_alu_full) w_pending[r_alu_addr] = 1'b1;
      if (r_acc_full) w_pending[r_acc_addr] = 1'b1;
      if (r_mem_full) w_pending[r_mem_addr] = 1'b1;
   end

   assign pending = w_pending;

endmodule
